ram8_dma: RTL and testbench
===========================

Name: ram8_dma

Overview:
- Block-transfer initiator that drives the write/read port of a RAM8-class memory: in, addr, load; async-read out.
- It either fills a contiguous address range from an input stream or dumps a range to an output stream.
- Sits between stream producers/consumers and the RAM8, and is the sole master of the RAM port.
- Transfers are started by a single command handshake.

Parameters:
- DATA_W, 16, word width; matches RAM data width.
- ADDR_W, 3, RAM address width; depth is 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = fill (stream -> RAM), 0 = dump (RAM -> stream).
- cmd_base  in  ADDR_W  first RAM address.
- cmd_count  in  ADDR_W+1  words to transfer, 0..2^ADDR_W.
- s_data  in  DATA_W  fill stream data.
- s_valid  in  1  fill stream valid.
- s_ready  out  1  fill stream ready.
- m_data  out  DATA_W  dump stream data, registered.
- m_valid  out  1  dump stream valid, registered.
- m_ready  in  1  dump stream ready.
- ram_in  out  DATA_W  RAM write data.
- ram_addr  out  ADDR_W  RAM address.
- ram_load  out  1  RAM write enable, sampled by the RAM at posedge clk.
- ram_out  in  DATA_W  RAM combinational read data for ram_addr.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at transfer completion.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; internal addr and remaining count = 0.
  - m_valid = 0, m_data = 0, done = 0, busy = 0.
  - cmd_ready = 1 once in IDLE.
  - s_ready = 0, ram_load = 0, ram_addr = 0, ram_in = 0.
  - Reset mid-transfer aborts immediately: ram_load drops combinationally, no further writes occur, and stream data in flight is discarded.
- States: IDLE, FILL, DUMP, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch addr <= cmd_base and rem <= cmd_count.
  - Next state: cmd_count == 0 -> DONE; else cmd_write ? FILL : DUMP.
  - ram_addr = addr, ram_load = 0.
- FILL:
  - s_ready = 1, ram_in = s_data, ram_addr = addr, ram_load = s_valid (combinational).
  - Each beat (s_valid & s_ready) writes the RAM at that edge; then addr <= addr + 1 (mod 2^ADDR_W) and rem <= rem - 1.
  - When the beat with rem == 1 is taken -> DONE.
  - Gaps in s_valid stall the transfer with no write.
  - Sustained throughput is 1 word/cycle.
- DUMP:
  - ram_addr = addr, ram_load = 0, ram_in = 0.
  - Output register advances when (!m_valid | m_ready):
    - if rem > 0: m_data <= ram_out, m_valid <= 1, addr++ (wraps), rem--;
    - else: m_valid <= 0.
  - m_data is held stable while m_valid & !m_ready.
  - First m_valid appears 1 cycle after the command edge.
  - Sustained throughput is 1 word/cycle under continuous m_ready.
  - Exit to DONE when rem == 0 and (!m_valid or m_ready) at the edge, i.e. the last word has been accepted.
  - m_valid is 0 on entry to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 1, cmd_ready = 0.
  - Next state is IDLE.
- Outside their modes: s_ready = 0 and m_valid = 0; stream inputs are ignored.
- Commands presented while busy are ignored (cmd_ready = 0) and must be held by the source.
- Address wrap: base + count beyond 2^ADDR_W - 1 wraps to 0; count = 2^ADDR_W touches every word exactly once.
- Widths: rem is ADDR_W+1 bits; addr is ADDR_W bits with natural overflow.
- No combinational path from m_ready to m_valid/m_data.
- Combinational paths s_valid -> ram_load and s_data -> ram_in are intentional.

Test Plan:
- Fill wrap:
  - Stimulus: cmd write, base 6, count 3, s_data 0xAAAA, 0xBBBB, 0xCCCC back-to-back.
  - Required: RAM[6] = 0xAAAA, RAM[7] = 0xBBBB, RAM[0] = 0xCCCC; done pulses the cycle after the 3rd beat; other words unchanged.
- Dump with backpressure:
  - Stimulus: RAM[i] = 0x1000 + i; cmd read, base 0, count 8; m_ready toggles 1,0,1,0...
  - Required: m_data sequence 0x1000..0x1007 in order, no duplicates or drops, data stable while stalled, done after the 8th accept.
- Zero count:
  - Stimulus: cmd count 0 (either mode).
  - Required: no ram_load, no m_valid, done high exactly one cycle after acceptance, then cmd_ready = 1.
- Fill with gaps:
  - Stimulus: count 2, s_valid pattern 1,0,0,1.
  - Required: exactly 2 writes at base and base + 1; ram_load low in the gap cycles.
- Reset mid-fill:
  - Stimulus: rst_n low after 1 of 4 beats.
  - Required: ram_load = 0 immediately; all outputs at reset values; only the first word written; a new command is accepted after release.
- Command while busy:
  - Stimulus: cmd_valid held during DUMP.
  - Required: cmd_ready = 0 until IDLE; the second command is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/ram8_dma.sv
// ram8_dma: block-transfer initiator and sole master of a RAM8-class memory port.
// A single command handshake starts one transfer. A fill writes a contiguous address
// range from the s_* stream. A dump reads a range out through the registered m_* stream.
// Addresses wrap modulo 2^ADDR_W.
//
// Ports:
//   clk, rst_n               clock shared with the RAM; asynchronous active-low reset
//   cmd_valid/ready          command handshake; cmd_write selects fill (1) or dump (0)
//   cmd_base, cmd_count      first address and word count (0..2^ADDR_W)
//   s_data/valid/ready       fill stream input
//   m_data/valid/ready       dump stream output (registered)
//   ram_in/addr/load         RAM write data, address, write enable
//   ram_out                  RAM combinational read data for ram_addr
//   busy, done               not idle; one-cycle completion pulse
module ram8_dma #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StFill, StDump, StDone} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = 1;
  localparam logic [ADDR_W:0]   RemOne  = 1;

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [ADDR_W:0]     r_rem, w_rem_d;
  logic [DATA_W-1:0]   r_m_data, w_m_data_d;
  logic                r_m_valid, w_m_valid_d;

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_rem_d     = r_rem;
    w_m_data_d  = r_m_data;
    w_m_valid_d = r_m_valid;
    cmd_ready   = 1'b0;
    s_ready     = 1'b0;
    ram_in      = '0;
    ram_addr    = r_addr;
    ram_load    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (r_state)
      StIdle: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_addr_d = cmd_base;
          w_rem_d  = cmd_count;
          if (cmd_count == '0) begin
            w_state_d = StDone;
          end else if (cmd_write) begin
            w_state_d = StFill;
          end else begin
            w_state_d = StDump;
          end
        end
      end

      StFill: begin
        s_ready = 1'b1;
        ram_in  = s_data;
        // Write enable follows s_valid directly so a beat lands in the same cycle.
        ram_load = s_valid;
        if (s_valid) begin
          w_addr_d = r_addr + AddrOne;
          w_rem_d  = r_rem - RemOne;
          if (r_rem == RemOne) begin
            w_state_d = StDone;
          end
        end
      end

      StDump: begin
        // Output register refills when empty or being drained; m_ready only
        // affects register enables, never m_valid/m_data combinationally.
        if (!r_m_valid || m_ready) begin
          if (r_rem != '0) begin
            w_m_data_d  = ram_out;
            w_m_valid_d = 1'b1;
            w_addr_d    = r_addr + AddrOne;
            w_rem_d     = r_rem - RemOne;
          end else begin
            w_m_valid_d = 1'b0;
            w_state_d   = StDone;
          end
        end
      end

      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end

      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_rem     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_addr    <= w_addr_d;
      r_rem     <= w_rem_d;
      r_m_data  <= w_m_data_d;
      r_m_valid <= w_m_valid_d;
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;

endmodule

// File: tb/tb_ram8_dma.sv
module tb_ram8_dma;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_count;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] ram_in;
  logic [AW-1:0] ram_addr;
  logic          ram_load;
  logic [DW-1:0] ram_out;
  logic          busy, done;

  // RAM model with a bench-side preload port.
  logic [DW-1:0] mem [8];
  logic [DW-1:0] exp_mem [8];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_in;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end
  assign ram_out = mem[ram_addr];

  ram8_dma #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load), .ram_out(ram_out),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic [7:0]    pat;       // per-cycle s_valid (fill) or m_ready (dump), bit 0 first
    logic [DW-1:0] seed;      // fill data = seed + beat * 0x1111
    int            exp_busy;  // cycles busy stays high, DONE included
    logic [AW-1:0] exp_end;   // internal address after completion (seen on ram_addr)
  } vec_t;

  vec_t vecs [9];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_mem(input string name);
    int idx = 0;
    bit found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && mem[i] !== exp_mem[i]) begin
        idx = i;
        found = 1'b1;
      end
    end
    chk(name, {16'h0, mem[idx]}, {16'h0, exp_mem[idx]});
  endtask

  task automatic run_xfer(input vec_t v);
    int cyc = 0;
    int beats = 0;
    int got = 0;
    int done_cnt = 0;
    int done_at = -1;
    logic [AW-1:0] a;
    cmd_write = v.wr;
    cmd_base  = v.base;
    cmd_count = v.cnt;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (busy && cyc < 100) begin
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
      if (v.wr) begin
        s_valid = v.pat[cyc % 8] && (beats < int'(v.cnt));
        s_data  = v.seed + 16'(beats) * 16'h1111;
        #1;
        chk("fill_load", {31'b0, ram_load}, {31'b0, s_valid});
        if (s_valid) begin
          a = v.base + 3'(beats);
          chk("fill_addr", {29'b0, ram_addr}, {29'b0, a});
          chk("fill_in", {16'h0, ram_in}, {16'h0, s_data});
          exp_mem[a] = s_data;
          beats++;
        end
      end else begin
        m_ready = v.pat[cyc % 8];
        #1;
        chk("dump_load", {31'b0, ram_load}, 32'd0);
        chk("dump_s_ready", {31'b0, s_ready}, 32'd0);
        if (m_valid) begin
          if (got >= int'(v.cnt)) begin
            chk("dump_extra_valid", {31'b0, m_valid}, 32'd0);
          end else begin
            a = v.base + 3'(got);
            chk("dump_data", {16'h0, m_data}, {16'h0, exp_mem[a]});
            if (m_ready) got++;
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    if (cyc >= 100) chk("xfer_timeout", {31'b0, busy}, 32'd0);
    if (v.wr) chk("fill_beats", beats, int'(v.cnt));
    else chk("dump_words", got, int'(v.cnt));
    chk("busy_cycles", cyc, v.exp_busy);
    chk("done_count", done_cnt, 1);
    chk("done_last_cycle", done_at, cyc - 1);
    chk("end_addr", {29'b0, ram_addr}, {29'b0, v.exp_end});
    chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("idle_m_valid", {31'b0, m_valid}, 32'd0);
    chk_mem("ram_contents");
  endtask

  initial begin
    int cyc;
    //            wr    base  cnt   pat     seed      busy end
    vecs[0] = '{1'b0, 3'd0, 4'd8, 8'h55, 16'h0000, 18, 3'd0}; // dump, toggling m_ready
    vecs[1] = '{1'b1, 3'd6, 4'd3, 8'hFF, 16'hAAAA, 4,  3'd1}; // fill wrap
    vecs[2] = '{1'b1, 3'd3, 4'd0, 8'hFF, 16'h0000, 1,  3'd3}; // zero count fill
    vecs[3] = '{1'b0, 3'd5, 4'd0, 8'hFF, 16'h0000, 1,  3'd5}; // zero count dump
    vecs[4] = '{1'b1, 3'd2, 4'd2, 8'h99, 16'h1234, 5,  3'd4}; // fill with gaps 1,0,0,1
    vecs[5] = '{1'b0, 3'd6, 4'd4, 8'hFF, 16'h0000, 6,  3'd2}; // dump wrap
    vecs[6] = '{1'b1, 3'd0, 4'd8, 8'hFF, 16'h0100, 9,  3'd0}; // full fill
    vecs[7] = '{1'b0, 3'd3, 4'd8, 8'hFF, 16'h0000, 10, 3'd3}; // full dump from 3
    vecs[8] = '{1'b0, 3'd4, 4'd2, 8'hFF, 16'h0000, 4,  3'd6}; // after reset abort

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_count = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;

    // Preload RAM[i] = 0x1000 + i while held in reset.
    for (int i = 0; i < 8; i++) begin
      bd_we = 1'b1;
      bd_addr = 3'(i);
      bd_data = 16'h1000 + 16'(i);
      exp_mem[i] = 16'h1000 + 16'(i);
      @(posedge clk); #1;
    end
    bd_we = 1'b0;

    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_data", {16'h0, m_data}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ram_load", {31'b0, ram_load}, 32'd0);
    chk("rst_ram_addr", {29'b0, ram_addr}, 32'd0);
    chk("rst_ram_in", {16'h0, ram_in}, 32'd0);
    chk_mem("preload");

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

    // Reset mid-fill: one of four beats lands, then reset during the second.
    cmd_write = 1'b1; cmd_base = 3'd4; cmd_count = 4'd4; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    s_valid = 1'b1;
    s_data = 16'hDEAD;
    #1;
    chk("abort_first_load", {31'b0, ram_load}, 32'd1);
    @(posedge clk); #1;
    exp_mem[4] = 16'hDEAD;
    s_data = 16'hBEEF;
    #1;
    chk("abort_second_load_pre", {31'b0, ram_load}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ram_load", {31'b0, ram_load}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_s_ready", {31'b0, s_ready}, 32'd0);
    chk("abort_m_valid", {31'b0, m_valid}, 32'd0);
    chk("abort_m_data", {16'h0, m_data}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_ram_addr", {29'b0, ram_addr}, 32'd0);
    chk("abort_ram_in", {16'h0, ram_in}, 32'd0);
    chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_mem("abort_ram_contents");
    run_xfer(vecs[8]);

    // Command held while busy: a dump, then a zero-count command waiting behind it.
    cmd_write = 1'b0; cmd_base = 3'd0; cmd_count = 4'd2; m_ready = 1'b1; cmd_valid = 1'b1;
    #1;
    chk("hold_first_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_base = 3'd7; cmd_count = 4'd0;
    cyc = 0;
    while (busy && cyc < 100) begin
      chk("hold_cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold_busy_cycles", cyc, 4);
    chk("hold_idle_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    chk("second_cmd_done", {31'b0, done}, 32'd1);
    chk("second_cmd_busy", {31'b0, busy}, 32'd1);
    cmd_valid = 1'b0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    chk("second_cmd_idle", {31'b0, busy}, 32'd0);
    chk("second_cmd_addr", {29'b0, ram_addr}, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
